axi4_lite_arbiter_2x1: RTL and testbench

Two-master, one-slave AXI4-Lite arbiter sharing the single external memory/MMIO port between the instruction fetch unit (master 0) and the load/store unit (master 1). It grants the slave port to one master for a complete transaction (address through response), forwards that master's channels combinationally, and holds the other master off until the transaction finishes. Only one transaction is outstanding at any time.

---
 rtl/axi_arb_pkg.sv | 18 +
 rtl/arb_pick2.sv | 29 ++
 rtl/axi4_lite_arbiter_2x1.sv | 208 ++++++++++++++++++++
 tb/tb_axi4_lite_arbiter_2x1.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI4-Lite arbiter.
package axi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2
   } arb_state_t;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] EXOKAY = 2'b01;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   localparam logic M_IFU = 1'b0;
   localparam logic M_LSU = 1'b1;

endpackage

// File: rtl/arb_pick2.sv
// Combinational 2-way grant picker: round-robin when AXI_ARB_RR_EN is defined,
// otherwise fixed priority with the LSU (master 1) ahead of the IFU (master 0).
module arb_pick2
   import axi_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant
);

`ifdef AXI_ARB_RR_EN
   always_comb begin
      unique case (req)
         2'b01:   grant = M_IFU;
         2'b10:   grant = M_LSU;
         2'b11:   grant = ~last_grant;
         default: grant = last_grant;
      endcase
   end
`else
   // With no request the previous grant is echoed; callers only sample grant when req != 0.
   always_comb begin
      if (req[1])      grant = M_LSU;
      else if (req[0]) grant = M_IFU;
      else             grant = last_grant;
   end
`endif

endmodule

// File: rtl/axi4_lite_arbiter_2x1.sv
// Two-master, one-slave AXI4-Lite arbiter: one whole transaction at a time, channels
// forwarded combinationally to the owner. Define AXI_ARB_RR_EN for round-robin arbitration.
module axi4_lite_arbiter_2x1
   import axi_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   // master 0 (instruction fetch)
   input  logic [ADDR_W-1:0]   m0_awaddr,
   input  logic                m0_awvalid,
   output logic                m0_awready,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [DATA_W/8-1:0] m0_wstrb,
   input  logic                m0_wvalid,
   output logic                m0_wready,
   output logic [1:0]          m0_bresp,
   output logic                m0_bvalid,
   input  logic                m0_bready,
   input  logic [ADDR_W-1:0]   m0_araddr,
   input  logic                m0_arvalid,
   output logic                m0_arready,
   output logic [DATA_W-1:0]   m0_rdata,
   output logic [1:0]          m0_rresp,
   output logic                m0_rvalid,
   input  logic                m0_rready,
   // master 1 (load/store)
   input  logic [ADDR_W-1:0]   m1_awaddr,
   input  logic                m1_awvalid,
   output logic                m1_awready,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   input  logic                m1_wvalid,
   output logic                m1_wready,
   output logic [1:0]          m1_bresp,
   output logic                m1_bvalid,
   input  logic                m1_bready,
   input  logic [ADDR_W-1:0]   m1_araddr,
   input  logic                m1_arvalid,
   output logic                m1_arready,
   output logic [DATA_W-1:0]   m1_rdata,
   output logic [1:0]          m1_rresp,
   output logic                m1_rvalid,
   input  logic                m1_rready,
   // shared slave port
   output logic [ADDR_W-1:0]   s_awaddr,
   output logic                s_awvalid,
   input  logic                s_awready,
   output logic [DATA_W-1:0]   s_wdata,
   output logic [DATA_W/8-1:0] s_wstrb,
   output logic                s_wvalid,
   input  logic                s_wready,
   input  logic [1:0]          s_bresp,
   input  logic                s_bvalid,
   output logic                s_bready,
   output logic [ADDR_W-1:0]   s_araddr,
   output logic                s_arvalid,
   input  logic                s_arready,
   input  logic [DATA_W-1:0]   s_rdata,
   input  logic [1:0]          s_rresp,
   input  logic                s_rvalid,
   output logic                s_rready
);

   arb_state_t state_q, state_d;
   logic       own_q, own_d;
   logic       aw_done_q, aw_done_d;
   logic       w_done_q, w_done_d;

   logic [1:0] req;
   logic       last_grant;
   logic       pick;
   logic       pick_aw;
   logic       sel;

   logic sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
   logic fwd_awready, fwd_wready, fwd_bvalid, fwd_arready, fwd_rvalid;

   assign req = {m1_awvalid | m1_arvalid, m0_awvalid | m0_arvalid};

   arb_pick2 u_pick (
      .req        (req),
      .last_grant (last_grant),
      .grant      (pick)
   );

`ifdef AXI_ARB_RR_EN
   logic last_grant_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                 last_grant_q <= M_IFU;
      else if ((state_q == IDLE) && (|req))    last_grant_q <= pick;
   end

   assign last_grant = last_grant_q;
`else
   assign last_grant = M_IFU;
`endif

   // A master raising awvalid and arvalid together is given the write first.
   assign pick_aw = (pick == M_LSU) ? m1_awvalid : m0_awvalid;

   // Payload muxes follow the owner; in IDLE they park on the IFU.
   assign sel = (state_q == IDLE) ? M_IFU : own_q;

   assign sel_awvalid = sel ? m1_awvalid : m0_awvalid;
   assign sel_wvalid  = sel ? m1_wvalid  : m0_wvalid;
   assign sel_bready  = sel ? m1_bready  : m0_bready;
   assign sel_arvalid = sel ? m1_arvalid : m0_arvalid;
   assign sel_rready  = sel ? m1_rready  : m0_rready;

   assign s_awaddr = sel ? m1_awaddr : m0_awaddr;
   assign s_wdata  = sel ? m1_wdata  : m0_wdata;
   assign s_wstrb  = sel ? m1_wstrb  : m0_wstrb;
   assign s_araddr = sel ? m1_araddr : m0_araddr;

   // NOTE: asynchronous active-high reset; every state bit gets a defined value while rst is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         own_q     <= M_IFU;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments for registers; blocking ones only inside always_comb.
         state_q   <= state_d;
         own_q     <= own_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block is defaulted first, so no path can infer a latch.
      state_d     = state_q;
      own_d       = own_q;
      aw_done_d   = aw_done_q;
      w_done_d    = w_done_q;
      s_awvalid   = 1'b0;
      s_wvalid    = 1'b0;
      s_bready    = 1'b0;
      s_arvalid   = 1'b0;
      s_rready    = 1'b0;
      fwd_awready = 1'b0;
      fwd_wready  = 1'b0;
      fwd_bvalid  = 1'b0;
      fwd_arready = 1'b0;
      fwd_rvalid  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (|req) begin
               own_d     = pick;
               state_d   = pick_aw ? WR : RD;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end

         RD: begin
            s_arvalid   = sel_arvalid;
            s_rready    = sel_rready;
            fwd_arready = s_arready;
            fwd_rvalid  = s_rvalid;
            if (s_rvalid && sel_rready) state_d = IDLE;
         end

         WR: begin
            // AW and W complete independently; each is closed off once it has handshaken.
            s_awvalid   = sel_awvalid & ~aw_done_q;
            s_wvalid    = sel_wvalid & ~w_done_q;
            fwd_awready = s_awready & ~aw_done_q;
            fwd_wready  = s_wready & ~w_done_q;
            if (s_awvalid && s_awready) aw_done_d = 1'b1;
            if (s_wvalid && s_wready)   w_done_d  = 1'b1;
            if (aw_done_q && w_done_q) begin
               s_bready   = sel_bready;
               fwd_bvalid = s_bvalid;
               if (s_bvalid && sel_bready) state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign m0_awready = fwd_awready & (own_q == M_IFU);
   assign m0_wready  = fwd_wready  & (own_q == M_IFU);
   assign m0_bvalid  = fwd_bvalid  & (own_q == M_IFU);
   assign m0_arready = fwd_arready & (own_q == M_IFU);
   assign m0_rvalid  = fwd_rvalid  & (own_q == M_IFU);
   assign m1_awready = fwd_awready & (own_q == M_LSU);
   assign m1_wready  = fwd_wready  & (own_q == M_LSU);
   assign m1_bvalid  = fwd_bvalid  & (own_q == M_LSU);
   assign m1_arready = fwd_arready & (own_q == M_LSU);
   assign m1_rvalid  = fwd_rvalid  & (own_q == M_LSU);

   // Response payloads are broadcast; only the owner ever sees a valid.
   assign m0_bresp = s_bresp;
   assign m0_rresp = s_rresp;
   assign m0_rdata = s_rdata;
   assign m1_bresp = s_bresp;
   assign m1_rresp = s_rresp;
   assign m1_rdata = s_rdata;

endmodule

// File: tb/tb_axi4_lite_arbiter_2x1.sv
// Directed bench for axi4_lite_arbiter_2x1 with a response scoreboard.
// Compile with AXI_ARB_RR_EN defined to check the round-robin build.
`timescale 1ns/1ps
module tb_axi4_lite_arbiter_2x1;
   import axi_arb_pkg::*;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic clk = 1'b0;
   logic rst;

   logic [ADDR_W-1:0] m0_awaddr, m1_awaddr, m0_araddr, m1_araddr, s_awaddr, s_araddr;
   logic              m0_awvalid, m1_awvalid, m0_awready, m1_awready;
   logic [DATA_W-1:0] m0_wdata, m1_wdata, s_wdata;
   logic [3:0]        m0_wstrb, m1_wstrb, s_wstrb;
   logic              m0_wvalid, m1_wvalid, m0_wready, m1_wready;
   logic [1:0]        m0_bresp, m1_bresp, m0_rresp, m1_rresp;
   logic              m0_bvalid, m1_bvalid, m0_bready, m1_bready;
   logic              m0_arvalid, m1_arvalid, m0_arready, m1_arready;
   logic [DATA_W-1:0] m0_rdata, m1_rdata, s_rdata;
   logic              m0_rvalid, m1_rvalid, m0_rready, m1_rready;
   logic              s_awvalid, s_awready, s_wvalid, s_wready;
   logic [1:0]        s_bresp, s_rresp;
   logic              s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;

   always #5 clk = ~clk;

   axi4_lite_arbiter_2x1 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst),
      .m0_awaddr(m0_awaddr), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
      .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wvalid(m0_wvalid), .m0_wready(m0_wready),
      .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
      .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
      .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
      .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
      .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
      .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
      .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
   );

   typedef struct {
      logic        mst;
      logic        is_wr;
      logic [31:0] data;
      logic [1:0]  resp;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   function automatic logic [14:0] hs_vec();
      return {m0_awready, m0_wready, m0_arready, m0_bvalid, m0_rvalid,
              m1_awready, m1_wready, m1_arready, m1_bvalid, m1_rvalid,
              s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_resp(input logic mst, input logic is_wr, input int budget);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (is_wr ? (mst ? m1_bvalid : m0_bvalid) : (mst ? m1_rvalid : m0_rvalid)) begin
            seen = 1'b1;
            break;
         end
      end
      check("resp_timeout", 32'(seen), 32'd1);
   endtask

   task automatic sb_compare();
      exp_t e;
      checks++;
      assert (sb.size() != 0)
      else begin
         errors++;
         $error("FAIL sb_empty observed=%0d expected=1", sb.size());
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         if (e.is_wr) begin
            check("b_owner_valid", 32'(e.mst ? m1_bvalid : m0_bvalid), 32'd1);
            check("b_other_valid", 32'(e.mst ? m0_bvalid : m1_bvalid), 32'd0);
            check("bresp", 32'(e.mst ? m1_bresp : m0_bresp), 32'(e.resp));
         end else begin
            check("r_owner_valid", 32'(e.mst ? m1_rvalid : m0_rvalid), 32'd1);
            check("r_other_valid", 32'(e.mst ? m0_rvalid : m1_rvalid), 32'd0);
            check("rdata", e.mst ? m1_rdata : m0_rdata, e.data);
            check("rresp", 32'(e.mst ? m1_rresp : m0_rresp), 32'(e.resp));
         end
      end
   endtask

   // Entered at the negedge of the cycle in which the owner's AR is being accepted.
   task automatic finish_read(input logic mst, input logic [31:0] data, input logic [1:0] resp);
      step();
      if (mst) begin m1_arvalid = 1'b0; m1_rready = 1'b1; end
      else     begin m0_arvalid = 1'b0; m0_rready = 1'b1; end
      s_rvalid = 1'b1;
      s_rdata  = data;
      s_rresp  = resp;
      sb.push_back('{mst, 1'b0, data, resp});
      wait_resp(mst, 1'b0, 4);
      sb_compare();
      step();
      s_rvalid  = 1'b0;
      m0_rready = 1'b0;
      m1_rready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      {m0_awaddr, m0_awvalid, m0_wdata, m0_wstrb, m0_wvalid, m0_bready, m0_araddr, m0_arvalid, m0_rready} = '0;
      {m1_awaddr, m1_awvalid, m1_wdata, m1_wstrb, m1_wvalid, m1_bready, m1_araddr, m1_arvalid, m1_rready} = '0;
      s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
      s_bvalid = 1'b0; s_bresp = OKAY; s_rvalid = 1'b0; s_rresp = OKAY; s_rdata = '0;

      // Reset: requests present while rst is high must not leak through.
      m0_arvalid = 1'b1;
      m1_awvalid = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_hs_zero", 32'(hs_vec()), 32'd0);
      check("reset_state", 32'(dut.state_q), 32'(IDLE));
      m0_arvalid = 1'b0;
      m1_awvalid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_reset_hs_zero", 32'(hs_vec()), 32'd0);

      // Single m0 read, slave answers in the third cycle after AR.
      step();
      m0_araddr  = 32'h8000_0000;
      m0_arvalid = 1'b1;
      @(negedge clk);
      check("t1_idle_m0_arready", 32'(m0_arready), 32'd0);
      check("t1_idle_s_arvalid", 32'(s_arvalid), 32'd0);
      step();
      @(negedge clk);
      check("t1_m0_arready", 32'(m0_arready), 32'd1);
      check("t1_s_arvalid", 32'(s_arvalid), 32'd1);
      check("t1_s_araddr", s_araddr, 32'h8000_0000);
      check("t1_m1_arready", 32'(m1_arready), 32'd0);
      step();
      m0_arvalid = 1'b0;
      m0_rready  = 1'b1;
      sb.push_back('{1'b0, 1'b0, 32'hDEAD_BEEF, OKAY});
      repeat (2) begin
         @(negedge clk);
         check("t1_no_early_rvalid", 32'(m0_rvalid), 32'd0);
         step();
      end
      s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; s_rresp = OKAY;
      wait_resp(1'b0, 1'b0, 4);
      sb_compare();
      check("t1_s_rready", 32'(s_rready), 32'd1);
      step();
      s_rvalid  = 1'b0;
      m0_rready = 1'b0;
      @(negedge clk);
      check("t1_back_to_idle", 32'(dut.state_q), 32'(IDLE));

      // Simultaneous: m0 read vs m1 write; m1 goes first in both builds.
      step();
      m0_araddr = 32'h3000_0000; m0_arvalid = 1'b1;
      m1_awaddr = 32'h8000_0010; m1_awvalid = 1'b1;
      m1_wdata = 32'h1234_5678; m1_wstrb = 4'hF; m1_wvalid = 1'b1; m1_bready = 1'b1;
      step();
      @(negedge clk);
      check("t2_m1_awready", 32'(m1_awready), 32'd1);
      check("t2_m1_wready", 32'(m1_wready), 32'd1);
      check("t2_s_awaddr", s_awaddr, 32'h8000_0010);
      check("t2_s_wdata", s_wdata, 32'h1234_5678);
      check("t2_s_wstrb", 32'(s_wstrb), 32'hF);
      check("t2_m0_arready_held", 32'(m0_arready), 32'd0);
      check("t2_s_arvalid", 32'(s_arvalid), 32'd0);
      step();
      m1_awvalid = 1'b0; m1_wvalid = 1'b0;
      s_bvalid = 1'b1; s_bresp = OKAY;
      sb.push_back('{1'b1, 1'b1, 32'h0, OKAY});
      wait_resp(1'b1, 1'b1, 4);
      sb_compare();
      check("t2_m0_arready_in_b", 32'(m0_arready), 32'd0);
      step();
      s_bvalid = 1'b0; m1_bready = 1'b0;
      @(negedge clk);
      check("t2_dead_cycle_arready", 32'(m0_arready), 32'd0);
      check("t2_dead_cycle_state", 32'(dut.state_q), 32'(IDLE));
      step();
      @(negedge clk);
      check("t2_m0_arready_late", 32'(m0_arready), 32'd1);
      check("t2_s_araddr", s_araddr, 32'h3000_0000);
      finish_read(1'b0, 32'hCAFE_F00D, EXOKAY);

      // m1 alone, then a tie: round-robin hands it to m0, fixed priority to m1.
      step();
      m1_araddr = 32'h4000_0000; m1_arvalid = 1'b1;
      step();
      @(negedge clk);
      check("t3_m1_arready", 32'(m1_arready), 32'd1);
      finish_read(1'b1, 32'h0000_4444, OKAY);
      m0_araddr = 32'h5000_0000; m0_arvalid = 1'b1;
      m1_araddr = 32'h6000_0000; m1_arvalid = 1'b1;
      step();
      @(negedge clk);
`ifdef AXI_ARB_RR_EN
      check("t3_tie_m0_arready", 32'(m0_arready), 32'd1);
      check("t3_tie_m1_arready", 32'(m1_arready), 32'd0);
      check("t3_tie_s_araddr", s_araddr, 32'h5000_0000);
      finish_read(1'b0, 32'h5555_0000, OKAY);
      step();
      @(negedge clk);
      check("t3_loser_arready", 32'(m1_arready), 32'd1);
      finish_read(1'b1, 32'h6666_0000, OKAY);
`else
      check("t3_tie_m1_arready", 32'(m1_arready), 32'd1);
      check("t3_tie_m0_arready", 32'(m0_arready), 32'd0);
      check("t3_tie_s_araddr", s_araddr, 32'h6000_0000);
      finish_read(1'b1, 32'h6666_0000, OKAY);
      step();
      @(negedge clk);
      check("t3_loser_arready", 32'(m0_arready), 32'd1);
      finish_read(1'b0, 32'h5555_0000, OKAY);
`endif

      // m0 write, W offered three cycles before AW; early slave B must be held off.
      step();
      s_awready = 1'b0;
      m0_wdata = 32'hA5A5_A5A5; m0_wstrb = 4'h3; m0_wvalid = 1'b1; m0_bready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("t4_idle_wready", 32'(m0_wready), 32'd0);
         step();
      end
      m0_awaddr = 32'h0000_1000; m0_awvalid = 1'b1;
      step();
      @(negedge clk);
      check("t4_m0_wready", 32'(m0_wready), 32'd1);
      check("t4_s_wstrb", 32'(s_wstrb), 32'h3);
      check("t4_m0_awready", 32'(m0_awready), 32'd0);
      check("t4_s_awvalid", 32'(s_awvalid), 32'd1);
      step();
      m0_wvalid = 1'b0;
      s_bvalid = 1'b1; s_bresp = SLVERR;
      @(negedge clk);
      check("t4_b_blocked_valid", 32'(m0_bvalid), 32'd0);
      check("t4_b_blocked_ready", 32'(s_bready), 32'd0);
      step();
      s_awready = 1'b1;
      @(negedge clk);
      check("t4_m0_awready_late", 32'(m0_awready), 32'd1);
      check("t4_b_still_blocked", 32'(m0_bvalid), 32'd0);
      step();
      m0_awvalid = 1'b0;
      sb.push_back('{1'b0, 1'b1, 32'h0, SLVERR});
      wait_resp(1'b0, 1'b1, 4);
      sb_compare();
      check("t4_s_bready", 32'(s_bready), 32'd1);
      step();
      s_bvalid = 1'b0; s_bresp = OKAY; m0_bready = 1'b0;
      @(negedge clk);
      check("t4_back_to_idle", 32'(dut.state_q), 32'(IDLE));

      // Backpressure: owner holds rready low while the slave offers data.
      step();
      m1_araddr = 32'h7000_0000; m1_arvalid = 1'b1; m1_rready = 1'b0;
      step();
      step();
      m1_arvalid = 1'b0;
      s_rvalid = 1'b1; s_rdata = 32'h0BAD_F00D; s_rresp = DECERR;
      sb.push_back('{1'b1, 1'b0, 32'h0BAD_F00D, DECERR});
      repeat (5) begin
         @(negedge clk);
         check("t5_s_rready_low", 32'(s_rready), 32'd0);
         check("t5_m1_rvalid", 32'(m1_rvalid), 32'd1);
         check("t5_state_rd", 32'(dut.state_q), 32'(RD));
         step();
      end
      m1_rready = 1'b1;
      wait_resp(1'b1, 1'b0, 2);
      sb_compare();
      check("t5_s_rready_high", 32'(s_rready), 32'd1);
      step();
      s_rvalid = 1'b0; m1_rready = 1'b0;
      @(negedge clk);
      check("t5_back_to_idle", 32'(dut.state_q), 32'(IDLE));

      // Reset mid-write (AW done, W pending), then a normal m0 read.
      step();
      s_wready = 1'b0;
      m0_awaddr = 32'h0000_2000; m0_awvalid = 1'b1;
      m0_wdata = 32'h7777_7777; m0_wstrb = 4'hF; m0_wvalid = 1'b1; m0_bready = 1'b1;
      step();
      step();
      m0_awvalid = 1'b0;
      @(negedge clk);
      check("t6_s_wvalid_pending", 32'(s_wvalid), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("t6_async_hs_zero", 32'(hs_vec()), 32'd0);
      check("t6_async_state", 32'(dut.state_q), 32'(IDLE));
      m0_wvalid = 1'b0; m0_bready = 1'b0; s_wready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("t6_post_reset_hs_zero", 32'(hs_vec()), 32'd0);
      step();
      m0_araddr = 32'h8000_0100; m0_arvalid = 1'b1;
      step();
      @(negedge clk);
      check("t6_m0_arready", 32'(m0_arready), 32'd1);
      finish_read(1'b0, 32'h1357_9BDF, OKAY);

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
